// File: rtl/proc_run_controller_if.sv
// Processor-side control/result bundle driven and observed by proc_run_controller.
// Contract: procReset_L/procStartPC are registered levels from the controller; currentPC/dMemOut are sampled every cycle.
interface proc_run_controller_if #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 64
);
  logic              procReset_L;
  logic [PC_W-1:0]   procStartPC;
  logic [PC_W-1:0]   currentPC;
  logic [DATA_W-1:0] dMemOut;

  modport master (output procReset_L, output procStartPC, input currentPC, input dMemOut);
  modport slave  (input procReset_L, input procStartPC, output currentPC, output dMemOut);
endinterface

// File: rtl/proc_run_controller.sv
// Run controller: resets the processor, releases it at a start PC, waits for an end PC
// (with optional watchdog), allows one settle cycle, then checks dMemOut against a pass code.
module proc_run_controller #(
  parameter int PC_W       = 64,
  parameter int DATA_W     = 64,
  parameter int RST_CYCLES = 1,
  parameter int WDOG_W     = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [PC_W-1:0]   cfgStartPC,
  input  logic [PC_W-1:0]   cfgEndPC,
  input  logic [DATA_W-1:0] cfgExpect,
  input  logic [WDOG_W-1:0] wdogLimit,
  proc_run_controller_if.master proc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [WDOG_W-1:0] cycleCount,
  output logic [DATA_W-1:0] resultData,
  output logic [2:0]        dbg_state
);

  localparam int RC_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_PROC = 3'd1,
    RUN        = 3'd2,
    SETTLE     = 3'd3,
    CHECK      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t            state;
  logic [RC_W-1:0]   rst_cnt;
  logic [PC_W-1:0]   end_pc;
  logic [DATA_W-1:0] expect_q;
  logic [WDOG_W-1:0] limit_q;

  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state            <= IDLE;
      rst_cnt          <= '0;
      end_pc           <= '0;
      expect_q         <= '0;
      limit_q          <= '0;
      proc.procReset_L <= 1'b0;
      proc.procStartPC <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      cycleCount       <= '0;
      resultData       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            end_pc           <= cfgEndPC;
            expect_q         <= cfgExpect;
            limit_q          <= wdogLimit;
            proc.procStartPC <= cfgStartPC;
            done             <= 1'b0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            cycleCount       <= '0;
            resultData       <= '0;
            rst_cnt          <= RC_W'(RST_CYCLES);
            busy             <= 1'b1;
            state            <= RESET_PROC;
          end
        end
        RESET_PROC: begin
          // Release the processor on the last counted reset cycle so RUN sees it running.
          if (rst_cnt <= RC_W'(1)) begin
            rst_cnt          <= '0;
            proc.procReset_L <= 1'b1;
            state            <= RUN;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          if (proc.currentPC >= end_pc) begin
            state <= SETTLE;
          end else if (limit_q != '0 && cycleCount == limit_q) begin
            timeout          <= 1'b1;
            pass             <= 1'b0;
            done             <= 1'b1;
            busy             <= 1'b0;
            proc.procReset_L <= 1'b0;
            state            <= DONE;
          end else if (cycleCount != '1) begin
            cycleCount <= cycleCount + 1'b1;
          end
        end
        SETTLE: state <= CHECK;
        CHECK: begin
          resultData       <= proc.dMemOut;
          pass             <= (proc.dMemOut == expect_q);
          done             <= 1'b1;
          busy             <= 1'b0;
          proc.procReset_L <= 1'b0;
          state            <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
